// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // All segments off on a common-anode display (active-low lines).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high patterns, bit0 = A ... bit6 = G; entry 15 is listed first.
  // b and d are lowercase glyphs, A/C/E/F uppercase.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table holds lit-high patterns; the pins are active-low.
  assign seg_n = ~SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits with a blanking gap per slot; optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
// Latency: outputs registered; a loaded value is shown BLANK_CLKS cycles after the next frame start.
// Backpressure: o_Load_Ready is low while a value waits for the frame boundary; a held i_Load_Valid is taken the cycle after the swap.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int BLANK_CLKS     = 500
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Enable,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Load_Valid,
  output logic                    o_Load_Ready,
  output logic [6:0]              o_Segment,
  output logic [NUM_DIGITS-1:0]   o_Digit,
  output logic                    o_Frame_Start
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CLKS - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic [VAL_W-1:0]      active_val;
  logic [VAL_W-1:0]      pending_val;
  logic                  pending_full;

  logic                  load_xfer;
  logic                  swap;
  logic [VAL_W-1:0]      disp_val;
  logic [3:0]            drive_nibble;
  logic [6:0]            drive_seg_raw;
  logic [6:0]            drive_seg;
  logic [NUM_DIGITS-1:0] drive_digit;
  logic                  lz_blank;

  assign load_xfer = i_Load_Valid && !pending_full;

  // o_Frame_Start is high exactly during the frame-start cycle, so it doubles
  // as the swap qualifier.
  assign swap = o_Frame_Start && pending_full;

  // With BLANK_CLKS = 1 the drive pattern is registered on the same edge as
  // the swap, so look through to the value that is about to become active.
  assign disp_val     = swap ? pending_val : active_val;
  assign drive_nibble = disp_val[idx*4 +: 4];

  seven_seg_decode u_decode (
    .nibble (drive_nibble),
    .seg_n  (drive_seg_raw)
  );

  // Digit idx is dark when it and every more significant nibble are zero.
  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && disp_val[4*i +: 4] != 4'h0) lz_blank = 1'b0;
    end
`endif
  end

  // Pattern and digit enable to register when a DRIVE phase begins.
  always_comb begin
    drive_digit      = '1;
    drive_digit[idx] = lz_blank;
    drive_seg        = lz_blank ? SEG_OFF : drive_seg_raw;
  end

  // Pending/active value registers and the load handshake.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      active_val   <= '0;
      pending_val  <= '0;
      pending_full <= 1'b0;
      o_Load_Ready <= 1'b1;
    end else if (swap) begin
      active_val   <= pending_val;
      pending_full <= 1'b0;
      o_Load_Ready <= 1'b1;
    end else if (load_xfer) begin
      pending_val  <= i_Value;
      pending_full <= 1'b1;
      o_Load_Ready <= 1'b0;
    end
  end

  // Scan state machine; every pin output is registered here.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || !i_Enable) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      o_Segment     <= SEG_OFF;
      o_Digit       <= '1;
      o_Frame_Start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state         <= BLANK;
          idx           <= '0;
          cnt           <= '0;
          o_Frame_Start <= 1'b1;
        end
        BLANK: begin
          o_Frame_Start <= 1'b0;
          cnt           <= cnt + CNT_W'(1);
          if (cnt == BLANK_LAST) begin
            state     <= DRIVE;
            o_Digit   <= drive_digit;
            o_Segment <= drive_seg;
          end
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            o_Frame_Start <= (idx == IDX_LAST);
            o_Digit       <= '1;
            o_Segment     <= SEG_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state         <= IDLE;
          idx           <= '0;
          cnt           <= '0;
          o_Segment     <= SEG_OFF;
          o_Digit       <= '1;
          o_Frame_Start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4 digits, 8-cycle slots, 2 blank cycles.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to exercise suppression.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int CPD   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * CPD;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Enable;
  logic [15:0] i_Value;
  logic        i_Load_Valid;
  logic        o_Load_Ready;
  logic [6:0]  o_Segment;
  logic [3:0]  o_Digit;
  logic        o_Frame_Start;

  int checks   = 0;
  int failures = 0;
  int fpos     = 0;

  logic [15:0] exp_active;
  logic [15:0] exp_pend_val;
  logic        exp_pend;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .CLKS_PER_DIGIT (CPD),
    .BLANK_CLKS     (BLK)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_Enable      (i_Enable),
    .i_Value       (i_Value),
    .i_Load_Valid  (i_Load_Valid),
    .o_Load_Ready  (o_Load_Ready),
    .o_Segment     (o_Segment),
    .o_Digit       (o_Digit),
    .o_Frame_Start (o_Frame_Start)
  );

  always #5 i_Clk = ~i_Clk;

  // Hand-written active-low glyphs, bit0 = A.
  function automatic logic [6:0] seg_lo(input logic [3:0] n);
    case (n)
      4'h0: seg_lo = 7'h40;  4'h1: seg_lo = 7'h79;
      4'h2: seg_lo = 7'h24;  4'h3: seg_lo = 7'h30;
      4'h4: seg_lo = 7'h19;  4'h5: seg_lo = 7'h12;
      4'h6: seg_lo = 7'h02;  4'h7: seg_lo = 7'h78;
      4'h8: seg_lo = 7'h00;  4'h9: seg_lo = 7'h10;
      4'hA: seg_lo = 7'h08;  4'hB: seg_lo = 7'h03;
      4'hC: seg_lo = 7'h46;  4'hD: seg_lo = 7'h21;
      4'hE: seg_lo = 7'h06;  default: seg_lo = 7'h0E;
    endcase
  endfunction

  function automatic logic lz(input logic [15:0] v, input int s);
    lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s != 0) lz = ((v >> (4 * s)) == 16'h0000);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h fpos=%0d t=%0t", tag, obs, exp, fpos, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_digit"}, o_Digit, 4'hF);
    check({tag, "_segment"}, o_Segment, 7'h7F);
    check({tag, "_frame_start"}, o_Frame_Start, 1'b0);
    check({tag, "_load_ready"}, o_Load_Ready, !exp_pend);
  endtask

  // Checks one running cycle at frame position fpos, then advances the
  // expected state and the clock. A successful load drops i_Load_Valid.
  task automatic cycle_check();
    int         slot;
    int         off;
    logic [3:0] ed;
    logic [6:0] es;
    logic       rdy_now;
    logic       xfer;
    slot = fpos / CPD;
    off  = fpos % CPD;
    ed   = 4'hF;
    es   = 7'h7F;
    if (off >= BLK && !lz(exp_active, slot)) begin
      ed[slot] = 1'b0;
      es       = seg_lo(exp_active[4*slot +: 4]);
    end
    rdy_now = !exp_pend;
    check("frame_start", o_Frame_Start, (fpos == 0));
    check("digit", o_Digit, ed);
    check("segment", o_Segment, es);
    check("load_ready", o_Load_Ready, rdy_now);
    xfer = i_Load_Valid && rdy_now;
    if (fpos == 0 && exp_pend) begin
      exp_active = exp_pend_val;
      exp_pend   = 1'b0;
    end
    if (xfer) begin
      exp_pend_val = i_Value;
      exp_pend     = 1'b1;
    end
    fpos = (fpos + 1) % FRAME;
    @(negedge i_Clk);
    if (xfer) begin
      i_Load_Valid = 1'b0;
      i_Value      = 16'hDEAD;
    end
  endtask

  initial begin
    i_Reset      = 1'b1;
    i_Enable     = 1'b0;
    i_Load_Valid = 1'b0;
    i_Value      = 16'hDEAD;
    exp_active   = 16'h0000;
    exp_pend_val = 16'h0000;
    exp_pend     = 1'b0;

    // Reset values, then idle with enable low.
    repeat (3) @(negedge i_Clk);
    check_idle("reset");
    i_Reset = 1'b0;
    @(negedge i_Clk);
    check_idle("idle_disabled");

    // Enable: frame start on the next cycle, two frames of 0000.
    i_Enable = 1'b1;
    @(negedge i_Clk);
    fpos = 0;
    repeat (2 * FRAME) cycle_check();

    // Mid-frame load of 1234; a second value is held while pending is full.
    repeat (10) cycle_check();
    i_Load_Valid = 1'b1;
    i_Value      = 16'h1234;
    cycle_check();
    cycle_check();
    i_Load_Valid = 1'b1;
    i_Value      = 16'hABCD;
    repeat (FRAME - 12) cycle_check();
    // 1234 for one full frame (ABCD taken at position 1), then ABCD.
    repeat (2 * FRAME) cycle_check();

    // Drop enable while digit 2 is driven, idle, then restart at digit 0.
    repeat (20) cycle_check();
    i_Enable = 1'b0;
    cycle_check();
    check_idle("disable");
    @(negedge i_Clk);
    check_idle("disabled_hold");
    i_Enable = 1'b1;
    @(negedge i_Clk);
    fpos = 0;
    repeat (FRAME) cycle_check();

    // Reset while pending is full: pending discarded, active back to 0.
    repeat (4) cycle_check();
    i_Load_Valid = 1'b1;
    i_Value      = 16'h9999;
    cycle_check();
    cycle_check();
    i_Reset = 1'b1;
    cycle_check();
    exp_active = 16'h0000;
    exp_pend   = 1'b0;
    check_idle("reset_mid");
    i_Reset = 1'b0;
    @(negedge i_Clk);
    fpos = 0;
    repeat (2 * FRAME) cycle_check();

    // Loads offered on the frame-start cycle land in pending (no bypass).
    i_Load_Valid = 1'b1;
    i_Value      = 16'h0050;
    repeat (2 * FRAME) cycle_check();
    i_Load_Valid = 1'b1;
    i_Value      = 16'h0000;
    repeat (2 * FRAME) cycle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
